mul64_seq: RTL and testbench
============================

Name: mul64_seq

Overview:
- Iterative 64x64 multiply sequencer for the Y86-64 execute stage.
- Drives one instance of the existing 64-bit adder/ALU (add64). It first takes operand magnitudes, then runs 64 shift-and-add iterations, then applies the sign.
- Returns the low 64 bits of the product plus an overflow flag.
- Uses a start/busy/done handshake. Latency is fixed and independent of the data.

Parameters:
- WIDTH, 64, operand/product width; must match add64.
- CNT_W, 7, iteration counter width; counts 0..WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  request; sampled only in IDLE
- a  in  WIDTH  multiplicand, captured when start is accepted
- b  in  WIDTH  multiplier, captured when start is accepted
- signed_op  in  1  1 = two's-complement multiply, 0 = unsigned; captured with the operands
- busy  out  1  high from ABS_A through FIX
- done  out  1  one-cycle pulse; product and overflow are valid
- product  out  WIDTH  low WIDTH bits of a*b; held until the next accepted start
- overflow  out  1  true product does not fit WIDTH bits in the selected signedness; held with product

Behaviour:
- Reset (asynchronous, any state, including mid-run):
  - state goes to IDLE.
  - busy=0, done=0, product=0, overflow=0.
  - All internal registers are cleared.
- States and transitions:
  - IDLE: start=1 accepts at edge E0. Capture a, b and signed_op. Record neg = signed_op & (a[63] ^ b[63]). Go to ABS_A.
  - ABS_A: the adder computes 0 - a (control 01) when signed_op & a[63]; otherwise the register passes through. The result is stored as M. Go to ABS_B.
  - ABS_B: same operation on b, stored as Q. Clear acc, counter and sticky flags. Go to RUN.
  - RUN (64 cycles, counter 0..63), each cycle:
    - If Q[0]=1: acc <= acc + M through the adder (control 00), and ovf_s |= carry | m_lost.
    - Then M <<= 1 and m_lost |= old M[63]; Q >>= 1.
    - Unsigned carry = (A[63]&B[63]) | ((A[63]|B[63]) & ~S[63]).
    - After counter=63, go to FIX.
  - FIX:
    - product register <= neg ? 0 - acc (control 01) : acc.
    - Unsigned: overflow <= ovf_s.
    - Signed: overflow <= ovf_s | (acc[63] & ~(neg & acc == 2^63)).
    - Go to DONE.
  - DONE: done=1 for this cycle only. Go to IDLE on the next edge.
- Latency:
  - done is high in the cycle following edge E67, where E0 is the accepting edge: 2 abs cycles + 64 RUN cycles + 1 FIX cycle.
  - The soonest next accept is the edge that ends IDLE, two edges after DONE is entered.
- Handshake rules:
  - start is ignored while busy=1 and in DONE.
  - No queueing: a dropped start must be re-asserted in IDLE.
  - Operand changes after acceptance have no effect.
- Adder usage:
  - The adder is the only arithmetic element; its control input is driven by the FSM only.
  - Adder inputs are 0 in IDLE and DONE; its output is ignored there.
- Boundary cases:
  - Zero operand gives product 0, overflow 0.
  - Signed -2^63 * 1 gives magnitude 2^63, neg=1, product 0x8000000000000000, overflow 0.
  - Signed -2^63 * -1 overflows.

Decomposition:
- Shared package (alu_pkg): ALU control encodings ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_XOR=2'b11; WIDTH; FSM state encoding.
- Sub-module: exactly one, an instance of the existing add64 (S, overflow, A, B, control).
- Everything else (FSM, shift registers, counter, sticky flags) lives in mul64_seq.

Test Plan:
- Unsigned a=3, b=5, start pulse: busy high for 67 cycles, then done pulse with product=15, overflow=0.
- Signed a=-3, b=5: product=0xFFFFFFFFFFFFFFF1, overflow=0. Signed a=-7, b=-6: product=42, overflow=0.
- Unsigned a=2^32, b=2^32: product=0, overflow=1. Unsigned a=0xFFFFFFFFFFFFFFFF, b=1: product=a, overflow=0.
- Signed -2^63 * 1: product=0x8000000000000000, overflow=0. Signed -2^63 * -1: overflow=1.
- start re-asserted with different operands while busy, and during DONE: ignored, and the first result is unchanged. A start in the following IDLE is accepted.
- rst asserted asynchronously at RUN iteration 30: outputs are 0 immediately and no done pulse occurs. After release, 30*30 gives product=900.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, adder/ALU control encodings and
// the multiply sequencer state encoding.
package alu_pkg;

  localparam int WIDTH = 64;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ABS_A = 3'd1,
    ST_ABS_B = 3'd2,
    ST_RUN   = 3'd3,
    ST_FIX   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/add64.sv
// 64-bit adder/ALU: S = A op B with the two's-complement overflow flag
// for add and subtract (cleared for the logic operations).
module add64
  import alu_pkg::*;
(
  output logic [WIDTH-1:0] S,
  output logic             overflow,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       control
);

  // Combinational operation select and signed-overflow detection.
  always_comb begin
    S        = '0;
    overflow = 1'b0;
    case (control)
      ALU_ADD: begin
        S        = A + B;
        overflow = (A[WIDTH-1] == B[WIDTH-1]) && (S[WIDTH-1] != A[WIDTH-1]);
      end
      ALU_SUB: begin
        S        = A - B;
        overflow = (A[WIDTH-1] != B[WIDTH-1]) && (S[WIDTH-1] != A[WIDTH-1]);
      end
      ALU_AND: S = A & B;
      ALU_XOR: S = A ^ B;
      default: S = '0;
    endcase
  end

endmodule

// File: rtl/mul64_seq.sv
// Iterative 64x64 multiplier built around a single add64 instance.
// Sequence: magnitude of a, magnitude of b, 64 shift-and-add steps, sign fix.
// Handshake: start is sampled only in IDLE; busy covers ABS_A..FIX; done is
// a one-cycle pulse and product/overflow stay valid until the next accept.
module mul64_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             sgn;
  logic             neg;
  logic [WIDTH-1:0] m_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf_s;
  logic             m_lost;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [1:0]       alu_ctl;
  logic [WIDTH-1:0] alu_s;
  logic             alu_ovf_unused;
  logic             carry;

  add64 u_add64 (
    .S        (alu_s),
    .overflow (alu_ovf_unused),
    .A        (alu_a),
    .B        (alu_b),
    .control  (alu_ctl)
  );

  // Adder operand/control steering; a pass-through is 0 + x through the adder.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_ctl = ALU_ADD;
    case (state)
      ST_ABS_A: begin
        alu_b   = a_reg;
        alu_ctl = (sgn && a_reg[WIDTH-1]) ? ALU_SUB : ALU_ADD;
      end
      ST_ABS_B: begin
        alu_b   = b_reg;
        alu_ctl = (sgn && b_reg[WIDTH-1]) ? ALU_SUB : ALU_ADD;
      end
      ST_RUN: begin
        alu_a = acc;
        alu_b = m_reg;
      end
      ST_FIX: begin
        alu_b   = acc;
        alu_ctl = neg ? ALU_SUB : ALU_ADD;
      end
      default: begin
        alu_a   = '0;
        alu_b   = '0;
        alu_ctl = ALU_ADD;
      end
    endcase
  end

  // Unsigned carry-out of the add, recovered from operand and sum MSBs.
  always_comb begin
    carry = (alu_a[WIDTH-1] & alu_b[WIDTH-1]) |
            ((alu_a[WIDTH-1] | alu_b[WIDTH-1]) & ~alu_s[WIDTH-1]);
  end

  // Sequencer FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      sgn      <= 1'b0;
      neg      <= 1'b0;
      m_reg    <= '0;
      q_reg    <= '0;
      acc      <= '0;
      cnt      <= '0;
      ovf_s    <= 1'b0;
      m_lost   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      product  <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            sgn   <= signed_op;
            neg   <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            busy  <= 1'b1;
            state <= ST_ABS_A;
          end
        end
        ST_ABS_A: begin
          m_reg <= alu_s;
          state <= ST_ABS_B;
        end
        ST_ABS_B: begin
          q_reg  <= alu_s;
          acc    <= '0;
          cnt    <= '0;
          ovf_s  <= 1'b0;
          m_lost <= 1'b0;
          state  <= ST_RUN;
        end
        ST_RUN: begin
          // A multiplier bit that meets a shifted-out multiplicand bit means
          // the true magnitude no longer fits, even if the sum does not carry.
          if (q_reg[0]) begin
            acc   <= alu_s;
            ovf_s <= ovf_s | carry | m_lost;
          end
          m_reg  <= m_reg << 1;
          m_lost <= m_lost | m_reg[WIDTH-1];
          q_reg  <= q_reg >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          product <= alu_s;
          // Signed: the magnitude must fit in WIDTH-1 bits, except that
          // 2^(WIDTH-1) is representable when the result is negative.
          if (sgn) begin
            overflow <= ovf_s | (acc[WIDTH-1] & ~(neg & (acc == MIN_NEG)));
          end else begin
            overflow <= ovf_s;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= ST_DONE;
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul64_seq.sv
// Bench for mul64_seq: directed vector table, handshake corner sequences,
// mid-run asynchronous reset, and randomized operands against a 128-bit
// arithmetic reference.
module tb_mul64_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [63:0] a;
  logic [63:0] b;
  logic        signed_op;
  logic        busy;
  logic        done;
  logic [63:0] product;
  logic        overflow;

  int checks;
  int failures;

  logic [64:0] exp_q[$];

  typedef struct {
    string       name;
    logic [63:0] a;
    logic [63:0] b;
    logic        s;
    logic [63:0] exp_p;
    logic        exp_o;
  } vec_t;

  vec_t vecs[9];

  mul64_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .signed_op (signed_op),
    .busy      (busy),
    .done      (done),
    .product   (product),
    .overflow  (overflow)
  );

  // Clock: 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: full-precision product, then range test on the true value.
  function automatic logic [64:0] model(input logic [63:0] x, input logic [63:0] y, input logic s);
    logic [127:0] full;
    logic         o;
    if (s) begin
      full = {{64{x[63]}}, x} * {{64{y[63]}}, y};
      o    = !((full[127:63] == '0) || (full[127:63] == '1));
    end else begin
      full = {64'd0, x} * {64'd0, y};
      o    = |full[127:64];
    end
    return {o, full[63:0]};
  endfunction

  // Issue one operation from IDLE and wait (bounded) for the done pulse.
  task automatic run_op(input logic [63:0] x, input logic [63:0] y, input logic s,
                        output logic [63:0] p, output logic o,
                        output int lat, output int bcnt);
    @(negedge clk);
    a = x; b = y; signed_op = s; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    signed_op = ~s;
    lat = 0; bcnt = 0; p = '0; o = 1'b0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (done) break;
      if (busy) bcnt++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL timeout actual=no_done required=done_within_200");
    end else begin
      p = product;
      o = overflow;
    end
  endtask

  initial begin
    logic [63:0] p;
    logic        o;
    int          lat;
    int          bcnt;
    logic [64:0] e;
    logic [63:0] x;
    logic [63:0] y;
    logic        s;
    bit          saw_done;

    checks = 0; failures = 0;
    start = 0; a = '0; b = '0; signed_op = 0;
    rst = 1'b1;

    vecs[0] = '{"u_3x5",       64'd3, 64'd5, 1'b0, 64'd15, 1'b0};
    vecs[1] = '{"s_m3x5",      -64'sd3, 64'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0};
    vecs[2] = '{"s_m7xm6",     -64'sd7, -64'sd6, 1'b1, 64'd42, 1'b0};
    vecs[3] = '{"u_2p32sq",    64'h1_0000_0000, 64'h1_0000_0000, 1'b0, 64'd0, 1'b1};
    vecs[4] = '{"u_maxx1",     64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[5] = '{"s_minx1",     64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h8000_0000_0000_0000, 1'b0};
    vecs[6] = '{"s_minxm1",    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'h8000_0000_0000_0000, 1'b1};
    vecs[7] = '{"s_zero",      64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'd0, 1'b0};
    vecs[8] = '{"u_maxxmax",   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd1, 1'b1};

    // Reset state.
    #3;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_product", product, 64'd0);
    check("rst_overflow", {63'd0, overflow}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed vector table, including latency and busy-width checks.
    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, p, o, lat, bcnt);
      check({vecs[i].name, "_product"}, p, vecs[i].exp_p);
      check({vecs[i].name, "_overflow"}, {63'd0, o}, {63'd0, vecs[i].exp_o});
      check({vecs[i].name, "_latency"}, 64'(lat), 64'd68);
      check({vecs[i].name, "_busy_cycles"}, 64'(bcnt), 64'd67);
    end

    // start held high with new operands while busy and through DONE.
    @(negedge clk);
    a = 64'd3; b = 64'd5; signed_op = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    a = 64'd7; b = 64'd9; start = 1'b1;
    lat = 10;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("ign_done_seen", {63'd0, done}, 64'd1);
    check("ign_latency", 64'(lat), 64'd68);
    check("ign_product", product, 64'd15);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("ign_idle_busy", {63'd0, busy}, 64'd0);
    check("ign_idle_done", {63'd0, done}, 64'd0);
    check("ign_held_product", product, 64'd15);
    run_op(64'd7, 64'd9, 1'b0, p, o, lat, bcnt);
    check("next_accept_product", p, 64'd63);
    check("next_accept_latency", 64'(lat), 64'd68);

    // Randomized operands through the scoreboard.
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 2))
        0: begin x = {$urandom, $urandom}; y = {$urandom, $urandom}; end
        1: begin x = 64'($urandom_range(0, 100000)); y = 64'($urandom_range(0, 100000)); end
        default: begin x = 64'($urandom); y = 64'($urandom_range(0, 65535)); end
      endcase
      s = 1'($urandom_range(0, 1));
      if (s && $urandom_range(0, 1) == 1) x = -x;
      if (s && $urandom_range(0, 1) == 1) y = -y;
      exp_q.push_back(model(x, y, s));
      run_op(x, y, s, p, o, lat, bcnt);
      e = exp_q.pop_front();
      check($sformatf("rand%0d_product", i), p, e[63:0]);
      check($sformatf("rand%0d_overflow", i), {63'd0, o}, {63'd0, e[64]});
    end

    // Asynchronous reset at RUN iteration 30.
    @(negedge clk);
    a = 64'd100; b = 64'd200; signed_op = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (33) @(negedge clk);
    check("pre_rst_busy", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_done", {63'd0, done}, 64'd0);
    check("mid_rst_product", product, 64'd0);
    check("mid_rst_overflow", {63'd0, overflow}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    check("post_rst_quiet", {63'd0, saw_done}, 64'd0);
    run_op(64'd30, 64'd30, 1'b0, p, o, lat, bcnt);
    check("post_rst_product", p, 64'd900);
    check("post_rst_overflow", {63'd0, o}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
